// File: rtl/qos_ingress_shaper_pkg.sv
// Shared constants and VC state encoding for the QoS ingress shaper.
package qos_ingress_shaper_pkg;

    localparam int unsigned QUEUE_QUANTITY = 4;
    localparam int unsigned BUF_WIDTH      = 3;
    localparam int unsigned HOLD_DEPTH     = 2;
    localparam int unsigned DROP_CNT_BITS  = 8;

    localparam int unsigned VC_BITS        = $clog2(QUEUE_QUANTITY);
    localparam int unsigned DATA_BITS      = BUF_WIDTH + 1;
    localparam int unsigned HOLD_CNT_BITS  = $clog2(HOLD_DEPTH) + 1;

    typedef enum logic [1:0] {
        VC_RUN    = 2'd0,
        VC_PAUSED = 2'd1,
        VC_ERROR  = 2'd2
    } vc_state_e;

endpackage

// File: rtl/qos_ingress_shaper_hold_fifo.sv
// Small per-VC holding queue with push/pop/flush and an occupancy count.
module ingress_hold_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage carries no reset; contents are only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Flush wins over a same-cycle push so an erroring VC ends empty.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/qos_ingress_shaper.sv
// Ingress shaper: per-VC hold queues, per-VC RUN/PAUSED/ERROR control and a
// round-robin issuer feeding the QoS block one word per cycle.
module qos_ingress_shaper
    import qos_ingress_shaper_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic                      in_valid,
    input  logic [VC_BITS-1:0]        in_vc,
    input  logic [DATA_BITS-1:0]      in_data,
    output logic                      in_ready,
    input  logic [QUEUE_QUANTITY-1:0] pausa,
    input  logic [QUEUE_QUANTITY-1:0] continuar,
    input  logic [QUEUE_QUANTITY-1:0] error_full,
    output logic                      out_valid,
    output logic [VC_BITS-1:0]        vc_id,
    output logic [DATA_BITS-1:0]      data_word,
    output logic [QUEUE_QUANTITY-1:0] vc_paused,
    output logic [QUEUE_QUANTITY-1:0] vc_error,
    output logic [DROP_CNT_BITS-1:0]  drop_count
);

    vc_state_e                 state_q [QUEUE_QUANTITY];
    logic [HOLD_CNT_BITS-1:0]  count   [QUEUE_QUANTITY];
    logic [DATA_BITS-1:0]      head    [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] push;
    logic [QUEUE_QUANTITY-1:0] pop;
    logic [QUEUE_QUANTITY-1:0] flush;
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic [VC_BITS-1:0]        rr_q;
    logic [VC_BITS-1:0]        rr_d;
    logic [VC_BITS-1:0]        win;
    logic                      found;
    logic                      issue;
    logic                      accept;
    logic                      in_vc_err;
    logic                      out_valid_q;
    logic [VC_BITS-1:0]        vc_id_q;
    logic [DATA_BITS-1:0]      data_word_q;
    logic [DROP_CNT_BITS-1:0]  drop_count_q;

    // Ready looks only at registered state, so it never depends on this cycle's issue.
    assign in_vc_err = (state_q[in_vc] == VC_ERROR);
    assign in_ready  = enb & (in_vc_err | (count[in_vc] < HOLD_CNT_BITS'(HOLD_DEPTH)));
    assign accept    = in_valid & in_ready;

    always_comb begin
        push      = '0;
        flush     = '0;
        eligible  = '0;
        vc_paused = '0;
        vc_error  = '0;
        for (int v = 0; v < int'(QUEUE_QUANTITY); v++) begin
            push[v]      = accept & ~in_vc_err & (in_vc == VC_BITS'(v));
            flush[v]     = enb & error_full[v] & (state_q[v] != VC_ERROR);
            eligible[v]  = (state_q[v] == VC_RUN) & (count[v] != '0);
            vc_paused[v] = (state_q[v] == VC_PAUSED);
            vc_error[v]  = (state_q[v] == VC_ERROR);
        end
    end

    // Round robin: first eligible VC at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < int'(QUEUE_QUANTITY); i++) begin
            if (!found && eligible[VC_BITS'((int'(rr_q) + i) % int'(QUEUE_QUANTITY))]) begin
                found = 1'b1;
                win   = VC_BITS'((int'(rr_q) + i) % int'(QUEUE_QUANTITY));
            end
        end
        issue = enb & found;
        rr_d  = (win == VC_BITS'(QUEUE_QUANTITY - 1)) ? '0 : win + VC_BITS'(1);
        pop   = '0;
        for (int v = 0; v < int'(QUEUE_QUANTITY); v++) begin
            pop[v] = issue & (win == VC_BITS'(v));
        end
    end

    for (genvar g = 0; g < int'(QUEUE_QUANTITY); g++) begin : g_vc
        ingress_hold_fifo #(
            .DEPTH (HOLD_DEPTH),
            .WIDTH (DATA_BITS)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .flush_i (flush[g]),
            .data_i  (in_data),
            .data_o  (head[g]),
            .count_o (count[g])
        );
    end

    // Per-VC control, arbiter pointer, drop counter and registered issue port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < int'(QUEUE_QUANTITY); v++) begin
                state_q[v] <= VC_RUN;
            end
            rr_q         <= '0;
            out_valid_q  <= 1'b0;
            vc_id_q      <= '0;
            data_word_q  <= '0;
            drop_count_q <= '0;
        end else if (enb) begin
            for (int v = 0; v < int'(QUEUE_QUANTITY); v++) begin
                if (error_full[v]) begin
                    state_q[v] <= VC_ERROR;
                end else if (state_q[v] == VC_RUN && pausa[v]) begin
                    state_q[v] <= VC_PAUSED;
                end else if (state_q[v] == VC_PAUSED && !pausa[v] && continuar[v]) begin
                    state_q[v] <= VC_RUN;
                end
            end
            if (issue) begin
                rr_q <= rr_d;
            end
            out_valid_q <= issue;
            vc_id_q     <= issue ? win : '0;
            data_word_q <= issue ? head[win] : '0;
            if (accept && in_vc_err && (drop_count_q != {DROP_CNT_BITS{1'b1}})) begin
                drop_count_q <= drop_count_q + DROP_CNT_BITS'(1);
            end
        end else begin
            out_valid_q <= 1'b0;
            vc_id_q     <= '0;
            data_word_q <= '0;
        end
    end

    assign out_valid  = out_valid_q;
    assign vc_id      = vc_id_q;
    assign data_word  = data_word_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_qos_ingress_shaper.sv
// Directed bench for qos_ingress_shaper with a queue-level reference model checked every cycle.
module tb_qos_ingress_shaper;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       in_valid;
    logic [1:0] in_vc;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] pausa;
    logic [3:0] continuar;
    logic [3:0] error_full;
    logic       out_valid;
    logic [1:0] vc_id;
    logic [3:0] data_word;
    logic [3:0] vc_paused;
    logic [3:0] vc_error;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    qos_ingress_shaper dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .in_valid   (in_valid),
        .in_vc      (in_vc),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pausa      (pausa),
        .continuar  (continuar),
        .error_full (error_full),
        .out_valid  (out_valid),
        .vc_id      (vc_id),
        .data_word  (data_word),
        .vc_paused  (vc_paused),
        .vc_error   (vc_error),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-VC word queues, per-VC state (0 run, 1 paused, 2 error).
    int         m_st [4] = '{0, 0, 0, 0};
    logic [3:0] m_q  [4][$];
    int         m_rr    = 0;
    int         m_drop  = 0;
    int         m_valid = 0;
    int         m_vc    = 0;
    int         m_data  = 0;
    int         m_win;
    bit         m_found;
    bit         m_rdy;

    always @(negedge clk) begin
        m_rdy = enb && (m_st[in_vc] == 2 || m_q[in_vc].size() < 2);
        check("cyc out_valid", int'(out_valid), m_valid);
        check("cyc vc_id", int'(vc_id), m_vc);
        check("cyc data_word", int'(data_word), m_data);
        check("cyc in_ready", int'(in_ready), int'(m_rdy));
        check("cyc drop_count", int'(drop_count), m_drop);
        for (int v = 0; v < 4; v++) begin
            check("cyc vc_paused", int'(vc_paused[v]), int'(m_st[v] == 1));
            check("cyc vc_error", int'(vc_error[v]), int'(m_st[v] == 2));
        end
        if (rst) begin
            for (int v = 0; v < 4; v++) begin
                m_st[v] = 0;
                m_q[v].delete();
            end
            m_rr = 0; m_drop = 0; m_valid = 0; m_vc = 0; m_data = 0;
        end else if (!enb) begin
            m_valid = 0; m_vc = 0; m_data = 0;
        end else begin
            m_found = 0;
            m_win   = 0;
            for (int k = 0; k < 4; k++) begin
                if (!m_found && m_st[(m_rr + k) % 4] == 0 && m_q[(m_rr + k) % 4].size() > 0) begin
                    m_found = 1;
                    m_win   = (m_rr + k) % 4;
                end
            end
            if (m_found) begin
                m_valid = 1;
                m_vc    = m_win;
                m_data  = int'(m_q[m_win].pop_front());
                m_rr    = (m_win + 1) % 4;
            end else begin
                m_valid = 0; m_vc = 0; m_data = 0;
            end
            if (in_valid && m_rdy) begin
                if (m_st[in_vc] == 2) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else m_q[in_vc].push_back(in_data);
            end
            for (int v = 0; v < 4; v++) begin
                if (error_full[v]) begin
                    m_st[v] = 2;
                    m_q[v].delete();
                end else if (m_st[v] != 2 && pausa[v]) begin
                    m_st[v] = 1;
                end else if (m_st[v] != 2 && continuar[v]) begin
                    m_st[v] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic send(input int vc, input int d);
        in_valid = 1'b1;
        in_vc    = 2'(vc);
        in_data  = 4'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic flags(input logic [3:0] p, input logic [3:0] c, input logic [3:0] e);
        pausa      = p;
        continuar  = c;
        error_full = e;
        tick();
        pausa      = '0;
        continuar  = '0;
        error_full = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int exp_vc [8];
    int exp_d  [8];

    initial begin
        rst = 1'b1; enb = 1'b1; in_valid = 1'b0; in_vc = '0; in_data = '0;
        pausa = '0; continuar = '0; error_full = '0;
        exp_vc = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_d  = '{1, 3, 5, 7, 2, 4, 6, 8};
        tick(); tick();
        rst = 1'b0;

        // Reset values
        look();
        check("rst out_valid", int'(out_valid), 0);
        check("rst in_ready", int'(in_ready), 1);
        check("rst drop_count", int'(drop_count), 0);
        check("rst vc_error", int'(vc_error), 0);
        tick();

        // Two back-to-back words: VC2 out one cycle before VC0
        send(2, 5);
        send(0, 10);
        look();
        check("t1 first valid", int'(out_valid), 1);
        check("t1 first vc", int'(vc_id), 2);
        check("t1 first data", int'(data_word), 5);
        look();
        check("t1 second vc", int'(vc_id), 0);
        check("t1 second data", int'(data_word), 10);
        tick();

        // Disabled: nothing accepted
        enb = 1'b0; in_valid = 1'b1; in_vc = 2'd1; in_data = 4'd7;
        look();
        check("enb0 in_ready", int'(in_ready), 0);
        tick();
        enb = 1'b1; in_valid = 1'b0;
        tick();

        // Paused VC1 fills and holds, then drains in order on continuar
        flags(4'b0010, 4'b0000, 4'b0000);
        send(1, 3);
        send(1, 4);
        look();
        check("t2 full in_ready", int'(in_ready), 0);
        check("t2 vc_paused", int'(vc_paused), 2);
        tick(); tick();
        flags(4'b0000, 4'b0010, 4'b0000);
        look();
        check("t2 not yet valid", int'(out_valid), 0);
        tick();
        look();
        check("t2 first vc", int'(vc_id), 1);
        check("t2 first data", int'(data_word), 3);
        check("t2 ready back", int'(in_ready), 1);
        tick();
        look();
        check("t2 second data", int'(data_word), 4);
        tick();

        // All four VCs with two words each, rr from 0
        rst = 1'b1; tick(); rst = 1'b0;
        flags(4'b1111, 4'b0000, 4'b0000);
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 2; k++) send(v, v * 2 + k + 1);
        end
        flags(4'b0000, 4'b1111, 4'b0000);
        look();
        tick();
        for (int i = 0; i < 8; i++) begin
            look();
            check("t3 valid", int'(out_valid), 1);
            check("t3 vc", int'(vc_id), exp_vc[i]);
            check("t3 data", int'(data_word), exp_d[i]);
            tick();
        end
        look();
        check("t3 idle after", int'(out_valid), 0);
        tick();

        // Error on VC3 with held words: flush, later words dropped
        flags(4'b1000, 4'b0000, 4'b0000);
        send(3, 12);
        send(3, 13);
        flags(4'b0000, 4'b0000, 4'b1000);
        look();
        check("t4 vc_error", int'(vc_error), 8);
        check("t4 vc_paused", int'(vc_paused), 0);
        tick();
        send(3, 1);
        send(3, 2);
        send(3, 3);
        in_vc = 2'd3;
        look();
        check("t4 drop_count", int'(drop_count), 3);
        check("t4 in_ready", int'(in_ready), 1);
        tick();
        flags(4'b0000, 4'b1000, 4'b0000);
        look();
        check("t4 error sticky", int'(vc_error), 8);
        tick();

        // Priority on VC0
        flags(4'b0001, 4'b0001, 4'b0000);
        look();
        check("t5 pause wins", int'(vc_paused), 1);
        tick();
        flags(4'b0001, 4'b0000, 4'b0001);
        look();
        check("t5 error wins", int'(vc_error), 9);
        check("t5 paused clear", int'(vc_paused), 0);
        tick();

        // Reset with words held everywhere
        flags(4'b0110, 4'b0000, 4'b0000);
        for (int v = 0; v < 4; v++) send(v, 9 + v);
        look();
        check("t6 drops before rst", int'(drop_count), 5);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        look();
        check("t6 out_valid", int'(out_valid), 0);
        check("t6 drop_count", int'(drop_count), 0);
        check("t6 vc_error", int'(vc_error), 0);
        tick();
        flags(4'b0000, 4'b1111, 4'b0000);
        tick();
        look();
        check("t6 queues empty", int'(out_valid), 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
